// File: rtl/twiddle_addr_gen_r22.sv
// rtl/twiddle_addr_gen_r22.sv - radix-2^2 SDF twiddle ROM address generator, one per multiplier stage.
// Optional quarter-ROM addressing with quadrant output: define TW_QUARTER_ROM_EN.
module twiddle_addr_gen_r22 #(
   parameter int NFFT  = 64,
   parameter int LOG2N = 6,
   parameter int STAGE = 0,
`ifdef TW_QUARTER_ROM_EN
   parameter int ADDR_W = LOG2N - 2
`else
   parameter int ADDR_W = LOG2N
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              dir,
   output logic              tw_valid,
   output logic [ADDR_W-1:0] tw_addr,
   output logic [1:0]        tw_quad,
   output logic              frame_done
);

   localparam int LOG2M = LOG2N - 2 * STAGE;
   localparam logic [LOG2N-1:0] QMASK = LOG2N'((NFFT >> (2 * STAGE + 2)) - 1);
   localparam logic [LOG2N-1:0] N_LAST = {LOG2N{1'b1}};

   typedef enum logic [0:0] {
      S_IDLE,
      S_RUN
   } state_t;

   state_t             state_q, state_d;
   logic [LOG2N-1:0]   n_q, n_d;
   logic               dir_lat_q, dir_lat_d;
   logic               tw_valid_q, tw_valid_d;
   logic [ADDR_W-1:0]  tw_addr_q, tw_addr_d;
   logic [1:0]         tw_quad_q, tw_quad_d;
   logic               frame_done_q, frame_done_d;

   logic [1:0]         p;
   logic [1:0]         p_rev;
   logic [LOG2N-1:0]   q;
   logic [LOG2N-1:0]   prod;
   logic [LOG2N-1:0]   e;
   logic [LOG2N-1:0]   e_rot;
   logic               dir_use;

   always_comb begin
      p     = n_q[LOG2M-1 -: 2];
      p_rev = {p[0], p[1]};
      q     = n_q & QMASK;
      // bitrev2(p) * q using only the two partial products q and 2q
      prod  = (p_rev[0] ? q : '0) + (p_rev[1] ? (q << 1) : '0);
      e     = prod << (2 * STAGE);
      // the first sample of a frame sees the fresh dir; its exponent is 0 anyway
      dir_use = (n_q == '0) ? dir : dir_lat_q;
      e_rot   = dir_use ? (~e + LOG2N'(1)) : e;
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      dir_lat_d    = dir_lat_q;
      tw_valid_d   = 1'b0;
      tw_addr_d    = tw_addr_q;
      tw_quad_d    = tw_quad_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
      if (in_valid) begin
         n_d          = n_q + LOG2N'(1);
         tw_valid_d   = 1'b1;
         frame_done_d = (n_q == N_LAST);
         if (n_q == '0) dir_lat_d = dir;
`ifdef TW_QUARTER_ROM_EN
         tw_addr_d = e_rot[LOG2N-3:0];
         tw_quad_d = e_rot[LOG2N-1:LOG2N-2];
`else
         tw_addr_d = e_rot;
         tw_quad_d = 2'b00;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         dir_lat_q    <= 1'b0;
         tw_valid_q   <= 1'b0;
         tw_addr_q    <= '0;
         tw_quad_q    <= 2'b00;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         dir_lat_q    <= dir_lat_d;
         tw_valid_q   <= tw_valid_d;
         tw_addr_q    <= tw_addr_d;
         tw_quad_q    <= tw_quad_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tw_valid   = tw_valid_q;
   assign tw_addr    = tw_addr_q;
   assign tw_quad    = tw_quad_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_twiddle_addr_gen_r22.sv
// tb/tb_twiddle_addr_gen_r22.sv - randomized and directed checks of twiddle_addr_gen_r22, stages 0 and 1.
module tb_twiddle_addr_gen_r22;

`ifdef TW_QUARTER_ROM_EN
   localparam int AW = 4;
`else
   localparam int AW = 6;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          dir = 1'b0;
   logic          v0, v1, fd0, fd1;
   logic [AW-1:0] a0, a1;
   logic [1:0]    q0, q1;

   int n_checks = 0;
   int n_pass   = 0;

   // reference state
   int  m_n = 0;
   bit  m_dl = 0;
   int  x_a0 = 0, x_a1 = 0, x_q0 = 0, x_q1 = 0;
   int  x_v = 0, x_fd = 0;
   int  last_n = 0;

   always #5 clk = ~clk;

   twiddle_addr_gen_r22 #(.NFFT(64), .LOG2N(6), .STAGE(0)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .dir(dir),
      .tw_valid(v0), .tw_addr(a0), .tw_quad(q0), .frame_done(fd0)
   );

   twiddle_addr_gen_r22 #(.NFFT(64), .LOG2N(6), .STAGE(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .dir(dir),
      .tw_valid(v1), .tw_addr(a1), .tw_quad(q1), .frame_done(fd1)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   function automatic int exponent(input int n, input int stage, input bit inv);
      int mm, m, p, q, br, e;
      mm = 64 / (4 ** stage);
      m  = n % mm;
      p  = m / (mm / 4);
      q  = m % (mm / 4);
      br = (p == 1) ? 2 : (p == 2) ? 1 : p;
      e  = br * q * (4 ** stage);
      if (inv) e = (64 - e) % 64;
      return e;
   endfunction

   function automatic int exp_addr(input int e);
`ifdef TW_QUARTER_ROM_EN
      return e % 16;
`else
      return e;
`endif
   endfunction

   function automatic int exp_quad(input int e);
`ifdef TW_QUARTER_ROM_EN
      return e / 16;
`else
      return 0;
`endif
   endfunction

   // one clock: drive, advance the reference, compare all outputs 1 ns after the edge
   task automatic cyc(input bit v, input bit d, input bit r);
      int e0, e1;
      rst = r; in_valid = v; dir = d;
      if (r) begin
         m_n = 0; m_dl = 0; x_v = 0; x_fd = 0;
         x_a0 = 0; x_a1 = 0; x_q0 = 0; x_q1 = 0;
      end else if (v) begin
         if (m_n == 0) m_dl = d;
         e0 = exponent(m_n, 0, m_dl);
         e1 = exponent(m_n, 1, m_dl);
         x_a0 = exp_addr(e0); x_q0 = exp_quad(e0);
         x_a1 = exp_addr(e1); x_q1 = exp_quad(e1);
         x_v = 1; x_fd = (m_n == 63);
         last_n = m_n;
         m_n = (m_n + 1) % 64;
      end else begin
         x_v = 0; x_fd = 0;
      end
      @(posedge clk); #1;
      check("valid0", v0, x_v);
      check("valid1", v1, x_v);
      check("addr0", a0, x_a0);
      check("addr1", a1, x_a1);
      check("quad0", q0, x_q0);
      check("quad1", q1, x_q1);
      check("fdone0", fd0, x_fd);
      check("fdone1", fd1, x_fd);
   endtask

   initial begin
      int cnt, seen;
      bit ok;
      cyc(0, 0, 1);
      cyc(1, 1, 1);
      check("rst_valid", v0, 0);
      check("rst_addr", a0, 0);
      check("rst_fd", fd0, 0);

      // FFT frame, continuous input
      for (int i = 0; i < 64; i++) begin
         cyc(1, 0, 0);
`ifndef TW_QUARTER_ROM_EN
         if (i < 16) check("fft_low", a0, 0);
         if (i == 17) check("fft_n17", a0, 2);
         if (i == 33) check("fft_n33", a0, 1);
         if (i == 63) check("fft_n63", a0, 45);
         if (i == 5)  check("s1_n5", a1, 8);
         if (i == 15) check("s1_n15", a1, 36);
         if (i == 21) check("s1_n21", a1, 8);
`else
         if (i == 63) begin
            check("qr_n63_quad", q0, 2);
            check("qr_n63_addr", a0, 13);
         end
`endif
         check("fd_pos", fd0, (i == 63) ? 1 : 0);
      end

      // IFFT frame back-to-back, dir toggled at n = 20
      for (int i = 0; i < 64; i++) begin
         cyc(1, (i < 20) ? 1'b1 : 1'b0, 0);
`ifndef TW_QUARTER_ROM_EN
         if (i == 5)  check("ifft_n5", a0, 0);
         if (i == 17) check("ifft_n17", a0, 62);
         if (i == 33) check("ifft_n33", a0, 63);
`else
         if (i == 17) begin
            check("qr_ifft_quad", q0, 3);
            check("qr_ifft_addr", a0, 14);
         end
`endif
      end

      // gapped input 1,0,0,1,...
      for (int i = 0; i < 90; i++) cyc((i % 3) == 0, 0, 0);

      // run to n = 40, then reset with in_valid high
      while (m_n != 40) cyc(1, 0, 0);
      cyc(1, 0, 1);
      cyc(1, 0, 0);
      check("post_rst_addr", a0, 0);
      check("post_rst_n", last_n, 0);
      cnt = 1; seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         cyc(1, 0, 0);
         cnt++;
         if (fd0) seen = cnt;
      end
      check("fd_after_rst", seen, 64);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         ok = ($urandom_range(99) == 0);
         cyc($urandom_range(3) != 0, $urandom_range(1) == 1, ok);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/twiddle_addr_gen_r22.md
# twiddle_addr_gen_r22

Parametrised twiddle-factor address generator for the radix-2² single-path delay-feedback (SDF) FFT/IFFT pipeline. One instance sits in front of each inter-stage complex multiplier. Per accepted sample it produces the twiddle ROM address for any transform size and any multiplier stage. It also provides:
- a run-time FFT/IFFT direction, latched per frame;
- gapped (non-continuous) input;
- a frame-done strobe.

## Interface
Parameters:
- NFFT, 64, transform size; power of two, 16..1024.
- LOG2N, 6, log2(NFFT).
- STAGE, 0, 0-based radix-2² section index feeding this multiplier. Must satisfy NFFT/4^STAGE ≥ 16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  a sample is present at the multiplier input this cycle.
- dir  input  1  0 = FFT, 1 = IFFT (conjugate twiddle); sampled only at frame start.
- tw_valid  output  1  tw_addr/tw_quad valid for the sample accepted last cycle.
- tw_addr  output  ADDR_W  twiddle ROM address. ADDR_W = LOG2N, or LOG2N-2 with TW_QUARTER_ROM_EN.
- tw_quad  output  2  quadrant rotation (-j)^tw_quad; constant 0 without TW_QUARTER_ROM_EN.
- frame_done  output  1  pulses with the tw_valid of the last sample (n = NFFT-1) of a frame.

## Operation
Sample counter:
- n, LOG2N bits, counts accepted samples 0..NFFT-1.
- Increments only on cycles with in_valid = 1.
- Wraps to 0 after NFFT-1. There are no idle cycles between frames.

Segment decomposition:
- M = NFFT/4^STAGE.
- m = n mod M.
- p = m / (M/4), 2 bits.
- q = m mod (M/4).

Exponent:
- e = bitrev2(p) × q × 4^STAGE, LOG2N bits.
- bitrev2 maps 0→0, 1→2, 2→1, 3→3.
- Maximum e is 3·(NFFT/4 − 4^STAGE) < NFFT, so no overflow is possible.
- Implement as shifts/adds of masked counter fields; no general multiplier required.

Direction:
- dir_lat is captured from dir on the cycle in_valid = 1 with n = 0.
- IFFT (dir_lat = 1): e' = (NFFT − e) mod NFFT, so e = 0 stays 0.
- FFT (dir_lat = 0): e' = e.
- A dir change mid-frame has no effect until the next n = 0.

Output mapping:
- Without TW_QUARTER_ROM_EN: tw_addr = e'.

States:
- IDLE: after reset; no frame in progress.
- RUN: entered on the first in_valid; stays in RUN across frame wraps.
- RUN→IDLE only via rst. The state is observable only through counter behaviour.

## Timing
- Latency 1: in_valid at cycle t with index n gives tw_valid = 1 at t+1, with tw_addr/tw_quad for n.
- All outputs are registered.
- in_valid = 0 at t:
  - tw_valid = 0 at t+1;
  - tw_addr/tw_quad hold their previous value;
  - n does not advance.
- frame_done is a 1-cycle pulse coincident with tw_valid for n = NFFT-1. It is 0 otherwise, including during gaps.
- Reset values: tw_valid = 0, tw_addr = 0, tw_quad = 0, frame_done = 0, n = 0, dir_lat = 0, state IDLE.
- Reset mid-frame:
  - the partial frame is discarded;
  - the next accepted sample is n = 0 and re-samples dir;
  - if rst and in_valid are high in the same cycle, rst wins and the sample is not counted.
- Back-to-back frames:
  - sample n = NFFT-1 is followed directly by n = 0 with a new dir latch;
  - frame_done for the old frame and the first output of the new frame are on consecutive cycles.

## Configuration
- TW_QUARTER_ROM_EN defined:
  - the ROM holds only W^0..W^(NFFT/4 − 1);
  - tw_quad = e'[LOG2N-1:LOG2N-2];
  - tw_addr = e'[LOG2N-3:0], ADDR_W = LOG2N-2;
  - the multiplier applies a swap/negate for tw_quad.
- TW_QUARTER_ROM_EN undefined:
  - full-ROM addressing, tw_addr = e', ADDR_W = LOG2N;
  - tw_quad = 0 always.

## Test plan
- NFFT = 64, STAGE = 0, FFT, continuous in_valid, n = 0..63:
  - n = 17 → tw_addr 2; n = 33 → 1; n = 63 → 45; n = 0..15 → 0;
  - frame_done only at the output for n = 63.
- Same configuration with dir = 1 at n = 0 → n = 17 gives 62, n = 33 gives 63, n = 5 gives 0. Toggling dir at n = 20 leaves the rest of the frame unchanged.
- NFFT = 64, STAGE = 1, FFT → n = 5 gives 8; n = 15 gives 36; n = 21 (m = 5) gives 8. The pattern repeats every 16 samples.
- Gapped input: in_valid toggled 1,0,0,1,…:
  - tw_valid follows in_valid delayed by 1;
  - addresses match the continuous-input sequence;
  - tw_addr holds during gaps.
- Reset asserted at n = 40, with in_valid high in the reset cycle:
  - the first output after release is for n = 0 with addr 0;
  - frame_done fires 64 accepted samples later, not 24.
- TW_QUARTER_ROM_EN, NFFT = 64, STAGE = 0 → FFT n = 63: tw_quad 2, tw_addr 13. IFFT n = 17: tw_quad 3, tw_addr 14.
